hbm_axi_resp_mem: RTL and testbench
===================================

// Module: hbm_axi_resp_mem
// PURPOSE
// AXI3 slave memory model standing in for one HBM pseudo-channel. It is the responder end of the per-channel AXI master that turns write_enable/read_enable requests into bursts.
// Instantiated 16x in place of the HBM IP for fast simulation/emulation. Single outstanding burst per direction; INCR only; IDs not carried.
// PARAMETERS
// ADDR_W     34    byte address width
// DATA_W     256   data width; one beat = 32 bytes
// MEM_DEPTH  1024  storage words, power of 2; index = ADDR[5 +: $clog2(MEM_DEPTH)], upper address bits aliased
// RD_LAT     4     AR handshake to first RVALID, cycles, >=1 (HBM_RESP_RDLAT_EN only)
// PORTS
// AXI_ACLK      in   1        clock
// AXI_ARESET_N  in   1        reset, asynchronous, active-low
// AXI_AWADDR    in   ADDR_W   write burst start byte address
// AXI_AWLEN     in   4        write beats minus 1
// AXI_AWVALID   in   1        AW valid
// AXI_AWREADY   out  1        AW ready
// AXI_WDATA     in   DATA_W   write data
// AXI_WSTRB     in   DATA_W/8 byte enables
// AXI_WLAST     in   1        last write beat
// AXI_WVALID    in   1        W valid
// AXI_WREADY    out  1        W ready
// AXI_BRESP     out  2        write response
// AXI_BVALID    out  1        B valid
// AXI_BREADY    in   1        B ready
// AXI_ARADDR    in   ADDR_W   read burst start byte address
// AXI_ARLEN     in   4        read beats minus 1
// AXI_ARVALID   in   1        AR valid
// AXI_ARREADY   out  1        AR ready
// AXI_RDATA     out  DATA_W   read data
// AXI_RRESP     out  2        read response, always OKAY
// AXI_RLAST     out  1        last read beat
// AXI_RVALID    out  1        R valid
// AXI_RREADY    in   1        R ready
// BEHAVIOUR
// - Reset: AWREADY=WREADY=BVALID=ARREADY=RVALID=RLAST=0; BRESP=RRESP=0; RDATA=0; FSMs to IDLE. Memory contents are not reset.
// - Write FSM WR_IDLE->WR_DATA->WR_RESP. In WR_IDLE, AWREADY=1. The AW handshake latches index and len; WREADY=1 from the next cycle.
// - Each W handshake writes the bytes with WSTRB=1, then index+1 (wraps MEM_DEPTH-1 -> 0).
// - WLAST on beat len: go to WR_RESP with BRESP=OKAY, BVALID the next cycle.
// - Early WLAST: end the burst, BRESP=SLVERR.
// - No WLAST at beat len: keep WREADY and discard further beats until WLAST, then BRESP=SLVERR.
// - BVALID/BRESP are held until BREADY. Then go to WR_IDLE, with AWREADY=1 the next cycle.
// - Read FSM RD_IDLE->RD_DATA. In RD_IDLE, ARREADY=1. RVALID=1 one cycle after the AR handshake, with RDATA=mem[index] and RLAST=(beat==len).
// - RDATA/RLAST are stable while RVALID & !RREADY. On each handshake the next beat is presented the next cycle (full throughput); index wraps.
// - The last R handshake returns to RD_IDLE.
// - Read and write FSMs are independent and run concurrently.
// - Same-cycle write and read-load of the same index: read returns old data (read-before-write).
// - Reset mid-burst: outputs go to reset values immediately; beats already written persist.
// CONFIGURATION
// HBM_RESP_RDLAT_EN defined: RD_WAIT state between RD_IDLE and RD_DATA, with a down-counter loaded with RD_LAT. First RVALID asserts RD_LAT cycles after the AR handshake; later beats are unaffected.
// Undefined: no RD_WAIT; first RVALID 1 cycle after AR. RD_LAT is ignored.
// STRUCTURE
// Package hbm_axi_pkg: AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, BEAT_BYTES=32, wr_state_t, rd_state_t.
// Sub-module hbm_resp_ram: 1W1R byte-enable array, DATA_W x MEM_DEPTH, registered read.
// TESTING
// 1. AW 0x0, len 0, WDATA='1, WSTRB='1 -> BVALID 1 cycle after W, BRESP=0. AR 0x0 len 0 -> RDATA='1, RLAST=1, RVALID 1 cycle after AR.
// 2. AW 0x20, len 15, data 0x4920+n -> read back 0x4920..0x492F in order, RLAST only on beat 15.
// 3. AW (MEM_DEPTH-1)*32, len 1 -> beat 1 lands at index 0. A read at 0x2000_0000 returns index 0.
// 4. AW len 3, WLAST on beat 2 -> BRESP=2'b10, beats 0-2 stored; AWREADY=1 one cycle after the B handshake.
// 5. RREADY 1/0 alternating on a 4-beat read -> RDATA/RLAST stable while stalled, exactly 4 handshakes. BREADY low 5 cycles -> BVALID/BRESP held.
// 6. AXI_ARESET_N low mid 8-beat read -> RVALID=0 at once, ARREADY=1 after release. With HBM_RESP_RDLAT_EN, RD_LAT=4 -> first RVALID 4 cycles after AR.

Source files
------------

// File: rtl/hbm_axi_pkg.sv
// rtl/hbm_axi_pkg.sv - shared constants and FSM state types for the HBM AXI responder
// Purpose: AXI response codes, beat geometry and the write/read FSM state types.
// Ports: none (package).
package hbm_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int BEAT_BYTES = 32;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/hbm_resp_ram.sv
// rtl/hbm_resp_ram.sv - 1W1R byte-enable storage array with registered read
// Purpose: DATA_W x DEPTH array; byte-masked write port, registered read port.
//   Array contents are never reset; only the read register is.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   we_i, waddr_i, wdata_i   write enable, word index, write data
//   wstrb_i                  per-byte write enables
//   re_i, raddr_i            read enable, word index
//   rdata_o                  registered read data, holds while re_i is low
module hbm_resp_ram #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                re_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // A same-edge write to raddr_i is not visible here: read-before-write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hbm_axi_resp_mem.sv
// rtl/hbm_axi_resp_mem.sv - AXI3 slave memory model for one HBM pseudo-channel
// Purpose: single-outstanding INCR burst responder per direction, backed by
//   hbm_resp_ram. Word index = address[5 +: log2(MEM_DEPTH)], upper bits alias.
// Optional macro: HBM_RESP_RDLAT_EN - inserts RD_WAIT so the first RVALID comes
//   RD_LAT cycles after the AR handshake; otherwise it comes one cycle after.
// Ports:
//   AXI_ACLK, AXI_ARESET_N                     clock, async active-low reset
//   AXI_AW{ADDR,LEN,VALID,READY}               write address channel
//   AXI_W{DATA,STRB,LAST,VALID,READY}          write data channel
//   AXI_B{RESP,VALID,READY}                    write response channel
//   AXI_AR{ADDR,LEN,VALID,READY}               read address channel
//   AXI_R{DATA,RESP,LAST,VALID,READY}          read data channel
module hbm_axi_resp_mem
  import hbm_axi_pkg::*;
#(
  parameter int ADDR_W    = 34,
  parameter int DATA_W    = 256,
  parameter int MEM_DEPTH = 1024,
  parameter int RD_LAT    = 4
) (
  input  logic                AXI_ACLK,
  input  logic                AXI_ARESET_N,
  input  logic [ADDR_W-1:0]   AXI_AWADDR,
  input  logic [3:0]          AXI_AWLEN,
  input  logic                AXI_AWVALID,
  output logic                AXI_AWREADY,
  input  logic [DATA_W-1:0]   AXI_WDATA,
  input  logic [DATA_W/8-1:0] AXI_WSTRB,
  input  logic                AXI_WLAST,
  input  logic                AXI_WVALID,
  output logic                AXI_WREADY,
  output logic [1:0]          AXI_BRESP,
  output logic                AXI_BVALID,
  input  logic                AXI_BREADY,
  input  logic [ADDR_W-1:0]   AXI_ARADDR,
  input  logic [3:0]          AXI_ARLEN,
  input  logic                AXI_ARVALID,
  output logic                AXI_ARREADY,
  output logic [DATA_W-1:0]   AXI_RDATA,
  output logic [1:0]          AXI_RRESP,
  output logic                AXI_RLAST,
  output logic                AXI_RVALID,
  input  logic                AXI_RREADY
);

  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int CNT_W     = 8;
  // RD_WAIT lasts RD_LAT-1 cycles: counter runs WAIT_LOAD..0 inclusive.
  localparam int WAIT_LOAD = (RD_LAT > 2) ? RD_LAT - 2 : 0;
`ifdef HBM_RESP_RDLAT_EN
  localparam bit RDLAT_EN = (RD_LAT > 1);
`else
  localparam bit RDLAT_EN = 1'b0;
`endif

  wr_state_t        wr_state_q, wr_state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [3:0]       wr_len_q, wr_len_d, wr_beat_q, wr_beat_d;
  logic             wr_ovf_q, wr_ovf_d;
  logic [1:0]       bresp_q, bresp_d;

  rd_state_t        rd_state_q, rd_state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [3:0]       rd_len_q, rd_len_d, rd_beat_q, rd_beat_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  // Holds every ready/valid low during reset and for the first cycle after it.
  logic             out_en_q;

  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic             unused_addr_bits;

  assign aw_hs = AXI_AWVALID & AXI_AWREADY;
  assign w_hs  = AXI_WVALID  & AXI_WREADY;
  assign b_hs  = AXI_BVALID  & AXI_BREADY;
  assign ar_hs = AXI_ARVALID & AXI_ARREADY;
  assign r_hs  = AXI_RVALID  & AXI_RREADY;

  assign unused_addr_bits = ^{AXI_AWADDR[ADDR_W-1:BEAT_SHIFT+IDX_W], AXI_AWADDR[BEAT_SHIFT-1:0],
                              AXI_ARADDR[ADDR_W-1:BEAT_SHIFT+IDX_W], AXI_ARADDR[BEAT_SHIFT-1:0]};

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
    if (!AXI_ARESET_N) begin
      out_en_q   <= 1'b0;
      wr_state_q <= WR_IDLE;
      wr_idx_q   <= '0;
      wr_len_q   <= '0;
      wr_beat_q  <= '0;
      wr_ovf_q   <= 1'b0;
      bresp_q    <= AXI_RESP_OKAY;
      rd_state_q <= RD_IDLE;
      rd_idx_q   <= '0;
      rd_len_q   <= '0;
      rd_beat_q  <= '0;
      rd_cnt_q   <= '0;
    end else begin
      out_en_q   <= 1'b1;
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_len_q   <= wr_len_d;
      wr_beat_q  <= wr_beat_d;
      wr_ovf_q   <= wr_ovf_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_len_q   <= rd_len_d;
      rd_beat_q  <= rd_beat_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // Write next state. wr_ovf_q marks a burst that passed beat len without
  // WLAST; further beats are accepted but not stored.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_len_d   = wr_len_q;
    wr_beat_d  = wr_beat_q;
    wr_ovf_d   = wr_ovf_q;
    bresp_d    = bresp_q;
    ram_we     = w_hs & ~wr_ovf_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          wr_state_d = WR_DATA;
          wr_idx_d   = AXI_AWADDR[BEAT_SHIFT +: IDX_W];
          wr_len_d   = AXI_AWLEN;
          wr_beat_d  = '0;
          wr_ovf_d   = 1'b0;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          if (!wr_ovf_q) begin
            wr_idx_d  = wr_idx_q + 1'b1;
            wr_beat_d = wr_beat_q + 4'd1;
          end
          if (AXI_WLAST) begin
            wr_state_d = WR_RESP;
            bresp_d    = (!wr_ovf_q && wr_beat_q == wr_len_q) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          end else if (!wr_ovf_q && wr_beat_q == wr_len_q) begin
            wr_ovf_d = 1'b1;
          end
        end
      end
      WR_RESP: begin
        if (b_hs) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read next state. The RAM read is issued on the AR handshake and on each
  // non-final R handshake, so its output register doubles as the R skid.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_len_d   = rd_len_q;
    rd_beat_d  = rd_beat_q;
    rd_cnt_d   = rd_cnt_q;
    ram_re     = 1'b0;
    ram_raddr  = rd_idx_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          ram_re     = 1'b1;
          ram_raddr  = AXI_ARADDR[BEAT_SHIFT +: IDX_W];
          rd_idx_d   = AXI_ARADDR[BEAT_SHIFT +: IDX_W] + 1'b1;
          rd_len_d   = AXI_ARLEN;
          rd_beat_d  = '0;
          rd_cnt_d   = CNT_W'(WAIT_LOAD);
          rd_state_d = RDLAT_EN ? RD_WAIT : RD_DATA;
        end
      end
      RD_WAIT: begin
        if (rd_cnt_q == '0) rd_state_d = RD_DATA;
        else                rd_cnt_d   = rd_cnt_q - 1'b1;
      end
      RD_DATA: begin
        if (r_hs) begin
          if (rd_beat_q == rd_len_q) begin
            rd_state_d = RD_IDLE;
          end else begin
            ram_re    = 1'b1;
            rd_idx_d  = rd_idx_q + 1'b1;
            rd_beat_d = rd_beat_q + 4'd1;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    AXI_AWREADY = out_en_q && (wr_state_q == WR_IDLE);
    AXI_WREADY  = out_en_q && (wr_state_q == WR_DATA);
    AXI_BVALID  = out_en_q && (wr_state_q == WR_RESP);
    AXI_ARREADY = out_en_q && (rd_state_q == RD_IDLE);
    AXI_RVALID  = out_en_q && (rd_state_q == RD_DATA);
    AXI_RLAST   = AXI_RVALID && (rd_beat_q == rd_len_q);
  end

  assign AXI_BRESP = bresp_q;
  assign AXI_RRESP = AXI_RESP_OKAY;
  assign AXI_RDATA = ram_rdata;

  hbm_resp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .AW     (IDX_W)
  ) u_ram (
    .clk_i   (AXI_ACLK),
    .rst_ni  (AXI_ARESET_N),
    .we_i    (ram_we),
    .waddr_i (wr_idx_q),
    .wdata_i (AXI_WDATA),
    .wstrb_i (AXI_WSTRB),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_hbm_axi_resp_mem.sv
// tb/tb_hbm_axi_resp_mem.sv - randomized self-checking bench for hbm_axi_resp_mem
module tb_hbm_axi_resp_mem;

  localparam int ADDR_W = 34;
  localparam int DATA_W = 256;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 4;
`ifdef HBM_RESP_RDLAT_EN
  localparam int EXP_LAT = RD_LAT;
`else
  localparam int EXP_LAT = 1;
`endif

  logic                clk;
  logic                rst_n;
  logic [ADDR_W-1:0]   AXI_AWADDR;
  logic [3:0]          AXI_AWLEN;
  logic                AXI_AWVALID, AXI_AWREADY;
  logic [DATA_W-1:0]   AXI_WDATA;
  logic [DATA_W/8-1:0] AXI_WSTRB;
  logic                AXI_WLAST, AXI_WVALID, AXI_WREADY;
  logic [1:0]          AXI_BRESP;
  logic                AXI_BVALID, AXI_BREADY;
  logic [ADDR_W-1:0]   AXI_ARADDR;
  logic [3:0]          AXI_ARLEN;
  logic                AXI_ARVALID, AXI_ARREADY;
  logic [DATA_W-1:0]   AXI_RDATA;
  logic [1:0]          AXI_RRESP;
  logic                AXI_RLAST, AXI_RVALID, AXI_RREADY;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0]   mdl [DEPTH];
  logic [DATA_W-1:0]   wq [$];
  logic [DATA_W/8-1:0] sq [$];

  hbm_axi_resp_mem #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .AXI_ACLK(clk), .AXI_ARESET_N(rst_n),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWLEN(AXI_AWLEN), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST), .AXI_WVALID(AXI_WVALID),
    .AXI_WREADY(AXI_WREADY), .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARLEN(AXI_ARLEN), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RLAST(AXI_RLAST), .AXI_RVALID(AXI_RVALID),
    .AXI_RREADY(AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd256();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'((a >> 5) % DEPTH);
  endfunction

  // Sends nsend beats from wq/sq for a burst of len+1 beats; WLAST on the last sent beat.
  task automatic wr_burst(input logic [ADDR_W-1:0] addr, input int len, input int nsend, input int bdelay);
    int idx, cyc;
    logic [1:0] exp_resp;
    logic [DATA_W-1:0] d;
    logic [DATA_W/8-1:0] s;
    idx = idx_of(addr);
    exp_resp = (nsend == len + 1) ? 2'b00 : 2'b10;
    AXI_AWADDR = addr; AXI_AWLEN = 4'(len); AXI_AWVALID = 1'b1;
    cyc = 0;
    while (!AXI_AWREADY && cyc < 50) begin tick(); cyc++; end
    chk("aw_wait", 256'(cyc < 50), 1);
    tick();
    AXI_AWVALID = 1'b0;
    chk("wready_after_aw", AXI_WREADY, 1);
    for (int i = 0; i < nsend; i++) begin
      AXI_WVALID = 1'b0;
      if ($urandom_range(3) == 0) tick();
      d = wq[i]; s = sq[i];
      AXI_WDATA = d; AXI_WSTRB = s; AXI_WLAST = (i == nsend - 1); AXI_WVALID = 1'b1;
      cyc = 0;
      while (!AXI_WREADY && cyc < 50) begin tick(); cyc++; end
      chk("w_wait", 256'(cyc < 50), 1);
      tick();
      if (i <= len) begin
        for (int j = 0; j < DATA_W / 8; j++)
          if (s[j]) mdl[(idx + i) % DEPTH][j*8 +: 8] = d[j*8 +: 8];
      end
    end
    AXI_WVALID = 1'b0; AXI_WLAST = 1'b0;
    wq.delete(); sq.delete();
    for (int k = 0; k < bdelay; k++) begin
      chk("bvalid_hold", AXI_BVALID, 1);
      chk("bresp_hold", AXI_BRESP, exp_resp);
      tick();
    end
    AXI_BREADY = 1'b1;
    chk("bvalid", AXI_BVALID, 1);
    chk("bresp", AXI_BRESP, exp_resp);
    tick();
    AXI_BREADY = 1'b0;
    chk("bvalid_clr", AXI_BVALID, 0);
    chk("awready_after_b", AXI_AWREADY, 1);
  endtask

  // mode 0: random RREADY, 1: alternating starting high, 2: always high
  task automatic rd_burst(input logic [ADDR_W-1:0] addr, input int len, input int mode);
    int idx, cyc, b;
    bit ph, rr;
    idx = idx_of(addr);
    AXI_ARADDR = addr; AXI_ARLEN = 4'(len); AXI_ARVALID = 1'b1;
    cyc = 0;
    while (!AXI_ARREADY && cyc < 50) begin tick(); cyc++; end
    chk("ar_wait", 256'(cyc < 50), 1);
    tick();
    AXI_ARVALID = 1'b0;
    for (int k = 1; k < EXP_LAT; k++) begin
      chk("rvalid_early", AXI_RVALID, 0);
      tick();
    end
    b = 0; cyc = 0; ph = 1'b1;
    while (b <= len && cyc < 200) begin
      rr = (mode == 2) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(1));
      ph = ~ph;
      AXI_RREADY = rr;
      chk("rvalid", AXI_RVALID, 1);
      chk("rdata", AXI_RDATA, mdl[(idx + b) % DEPTH]);
      chk("rlast", AXI_RLAST, 256'(b == len));
      chk("rresp", AXI_RRESP, 0);
      tick();
      cyc++;
      if (rr) b++;
    end
    AXI_RREADY = 1'b0;
    chk("r_beats", b, len + 1);
    chk("rvalid_end", AXI_RVALID, 0);
    chk("arready_end", AXI_ARREADY, 1);
  endtask

  initial begin
    logic [ADDR_W-1:0] wa;
    int wl, wb, rl, rb, ns;
    rst_n = 1'b0;
    AXI_AWADDR = '0; AXI_AWLEN = '0; AXI_AWVALID = 1'b0;
    AXI_WDATA = '0; AXI_WSTRB = '0; AXI_WLAST = 1'b0; AXI_WVALID = 1'b0; AXI_BREADY = 1'b0;
    AXI_ARADDR = '0; AXI_ARLEN = '0; AXI_ARVALID = 1'b0; AXI_RREADY = 1'b0;
    repeat (3) tick();
    chk("rst_awready", AXI_AWREADY, 0);
    chk("rst_wready", AXI_WREADY, 0);
    chk("rst_bvalid", AXI_BVALID, 0);
    chk("rst_bresp", AXI_BRESP, 0);
    chk("rst_arready", AXI_ARREADY, 0);
    chk("rst_rvalid", AXI_RVALID, 0);
    chk("rst_rlast", AXI_RLAST, 0);
    chk("rst_rdata", AXI_RDATA, 0);
    chk("rst_rresp", AXI_RRESP, 0);
    rst_n = 1'b1;
    tick();
    chk("arready_idle", AXI_ARREADY, 1);

    // Fill the whole array so every later read has a defined expectation.
    for (int g = 0; g < DEPTH / 16; g++) begin
      for (int n = 0; n < 16; n++) begin wq.push_back(rnd256()); sq.push_back('1); end
      wr_burst(ADDR_W'(g * 16 * 32), 15, 16, 0);
    end

    wq.push_back('1); sq.push_back('1);
    wr_burst(34'h0, 0, 1, 0);
    rd_burst(34'h0, 0, 2);
    chk("t1_model", mdl[0], '1);

    for (int n = 0; n < 16; n++) begin wq.push_back(DATA_W'(32'h4920 + n)); sq.push_back('1); end
    wr_burst(34'h20, 15, 16, 0);
    rd_burst(34'h20, 15, 2);

    for (int n = 0; n < 2; n++) begin wq.push_back(rnd256()); sq.push_back('1); end
    wr_burst(ADDR_W'((DEPTH - 1) * 32), 1, 2, 0);
    rd_burst(34'h2000_0000, 0, 2);
    rd_burst(ADDR_W'((DEPTH - 1) * 32), 1, 0);

    for (int n = 0; n < 3; n++) begin wq.push_back(rnd256()); sq.push_back('1); end
    wr_burst(ADDR_W'(256 * 32), 3, 3, 0);
    rd_burst(ADDR_W'(256 * 32), 3, 0);

    for (int n = 0; n < 4; n++) begin wq.push_back(rnd256()); sq.push_back('1); end
    wr_burst(ADDR_W'(300 * 32), 1, 4, 2);
    rd_burst(ADDR_W'(300 * 32), 3, 0);

    for (int n = 0; n < 4; n++) begin wq.push_back(rnd256()); sq.push_back($urandom()); end
    wr_burst(ADDR_W'(400 * 32), 3, 4, 5);
    rd_burst(ADDR_W'(400 * 32), 3, 1);

    // Reset in the middle of an 8-beat read.
    AXI_ARADDR = ADDR_W'(600 * 32); AXI_ARLEN = 4'd7; AXI_ARVALID = 1'b1;
    tick();
    AXI_ARVALID = 1'b0;
    repeat (EXP_LAT - 1) tick();
    AXI_RREADY = 1'b1;
    tick(); tick();
    chk("mid_rvalid", AXI_RVALID, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_rvalid", AXI_RVALID, 0);
    chk("arst_rlast", AXI_RLAST, 0);
    chk("arst_rdata", AXI_RDATA, 0);
    chk("arst_arready", AXI_ARREADY, 0);
    chk("arst_awready", AXI_AWREADY, 0);
    AXI_RREADY = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("arready_after_rst", AXI_ARREADY, 1);
    chk("awready_after_rst", AXI_AWREADY, 1);
    rd_burst(ADDR_W'(600 * 32), 7, 0);
    rd_burst(ADDR_W'(256 * 32), 2, 2);

    // Random concurrent write/read on disjoint regions, then read the write back.
    for (int it = 0; it < 24; it++) begin
      wl = $urandom_range(15); wb = $urandom_range(495);
      rl = $urandom_range(15); rb = 512 + $urandom_range(496);
      ns = wl + 1;
      if (it % 6 == 4) ns = wl + 1 + $urandom_range(1, 3);
      if (it % 6 == 5 && wl > 0) ns = $urandom_range(1, wl);
      for (int n = 0; n < ns; n++) begin
        wq.push_back(rnd256());
        sq.push_back((it % 3 == 0) ? DATA_W'($urandom()) : '1);
      end
      wa = ADDR_W'(wb * 32) | (ADDR_W'($urandom_range(511)) << 15) | ADDR_W'($urandom_range(31));
      fork
        wr_burst(wa, wl, ns, $urandom_range(3));
        rd_burst(ADDR_W'(rb * 32), rl, 0);
      join
      rd_burst(wa, wl, $urandom_range(2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
